// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - dot-product sequencer driving a 4-bit multiply-accumulate datapath
// Owns the accumulator: cleared at job start, updated per accepted beat, held until taken.
module mac_dot_seq #(
  parameter int DATA_W = 4,
  parameter int LEN_W  = 4,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   count;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   prod;
  logic               last_beat;

  // Operands are widened before the multiply so the product is zero-extended.
  assign prod      = ACC_W'(A) * ACC_W'(B);
  assign last_beat = (count == len_q - LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      len_q <= '0;
      count <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            count <= '0;
            acc   <= '0;
            state <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // abort wins over a coincident beat, including the last one
          if (abort) begin
            count <= '0;
            acc   <= '0;
            state <= IDLE;
          end else if (in_valid) begin
            acc   <= acc + prod;
            count <= count + LEN_W'(1);
            if (last_beat) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pure decodes of the state register; reset clears them without a clock edge.
  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = acc;

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb/tb_mac_dot_seq.sv - scoreboard bench for mac_dot_seq with randomized jobs
module tb_mac_dot_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  len;
  logic        abort;
  logic [3:0]  op_a;
  logic [3:0]  op_b;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] result;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int va[16];
  int vb[16];

  mac_dot_seq #(.DATA_W(4), .LEN_W(4), .ACC_W(12)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .len(len),
    .abort(abort),
    .A(op_a),
    .B(op_b),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .result(result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle a result is presented it must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %0d expected none at %0t", result, $time);
      end else begin
        check("result", 32'(result), exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Entered and left at posedge+1. vmode: 0 continuous, 1 toggled, 2 random valid.
  task automatic drive_job(input int n, input int vmode, input int hold);
    int sum = 0;
    int idx = 0;
    int cyc = 0;
    bit v;
    for (int i = 0; i < n; i++) sum += va[i] * vb[i];
    exp_q.push_back(sum);
    out_ready = 1'b0;
    start = 1'b1;
    len = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    while (idx < n && cyc < 200) begin
      check("in_ready_run", 32'(in_ready), 1);
      check("out_valid_run", 32'(out_valid), 0);
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      in_valid = v;
      op_a = 4'(va[idx]);
      op_b = 4'(vb[idx]);
      @(posedge clk); #1;
      cyc++;
      if (v) idx++;
    end
    check("beats_accepted", 32'(idx), 32'(n));
    // Surplus valid data must not be consumed once the job is done.
    in_valid = 1'b1;
    op_a = 4'($urandom_range(0, 15));
    op_b = 4'($urandom_range(0, 15));
    check("in_ready_done", 32'(in_ready), 0);
    check("out_valid_done", 32'(out_valid), 1);
    check("busy_done", 32'(busy), 1);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      len = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check("out_valid_hold", 32'(out_valid), 1);
      check("in_ready_hold", 32'(in_ready), 0);
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_take", 32'(out_valid), 0);
    check("busy_after_take", 32'(busy), 0);
  endtask

  task automatic abort_job();
    start = 1'b1;
    len = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      op_a = 4'd7;
      op_b = 4'd9;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    in_valid = 1'b1;
    check("in_ready_at_abort", 32'(in_ready), 1);
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    check("busy_after_abort", 32'(busy), 0);
    check("in_ready_after_abort", 32'(in_ready), 0);
    check("out_valid_after_abort", 32'(out_valid), 0);
  endtask

  task automatic reset_mid_run();
    start = 1'b1;
    len = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      op_a = 4'd5;
      op_b = 4'd6;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    len = '0;
    abort = 1'b0;
    op_a = '0;
    op_b = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 0);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_result", 32'(result), 0);
    reset = 1'b0;

    va[0] = 2;  vb[0] = 3;
    va[1] = 4;  vb[1] = 5;
    va[2] = 15; vb[2] = 15;
    drive_job(3, 0, 0);

    for (int i = 0; i < 15; i++) begin va[i] = 15; vb[i] = 15; end
    drive_job(15, 1, 0);

    drive_job(0, 0, 0);

    va[0] = 9; vb[0] = 11; va[1] = 13; vb[1] = 2;
    drive_job(2, 0, 5);

    abort_job();
    va[0] = 3; vb[0] = 3;
    drive_job(1, 0, 0);

    reset_mid_run();
    va[0] = 1; vb[0] = 1; va[1] = 1; vb[1] = 1;
    drive_job(2, 0, 0);

    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < 16; i++) begin
        va[i] = int'($urandom_range(0, 15));
        vb[i] = int'($urandom_range(0, 15));
      end
      drive_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Sequencer that drives a 4-bit multiply-accumulate datapath over a stream of operand pairs. It computes the dot product of two vectors of programmable length, from 0 to 15 elements. It sits between an operand source (valid/ready stream) and a result consumer (valid/ready). It owns the accumulator: clearing it at job start, gating accumulation per accepted beat, and holding the final sum until the consumer takes it.

## Interface
Parameters:
- DATA_W, 4, operand width of A and B.
- LEN_W, 4, width of the job length field; max length 2^LEN_W-1.
- ACC_W, 12, accumulator/result width; must be ≥ 2*DATA_W+LEN_W.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- start  input  1  job request; sampled only in IDLE.
- len  input  LEN_W  number of operand pairs in the job; sampled with start.
- abort  input  1  cancels an in-progress job; sampled only in RUN.
- A  input  DATA_W  unsigned operand A.
- B  input  DATA_W  unsigned operand B.
- in_valid  input  1  A/B valid.
- in_ready  output  1  sequencer accepts A/B this cycle.
- result  output  ACC_W  unsigned dot-product result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 with len=0: go to DONE; accumulator=0.
  - On start=1 with len≠0: go to RUN; latch len; count=0; accumulator=0.
  - start=0: stay in IDLE.
- RUN:
  - A beat is in_valid & in_ready. On each beat: accumulator += A*B, where the product is zero-extended to ACC_W; count += 1.
  - Beat with count == len_latched-1: go to DONE; the final sum, including this beat, is registered into the accumulator.
  - abort=1: go to IDLE; accumulator cleared; any beat in the same cycle is dropped and in_ready is still high. abort has priority over a last beat.
- DONE:
  - out_valid=1; result=accumulator, held stable.
  - On out_ready=1: go to IDLE.
- start outside IDLE is ignored; there is no queuing. abort outside RUN is ignored.
- in_ready = (state==RUN), decoded from the state register only; it has no combinational path from inputs.
- out_valid = (state==DONE); busy = (state≠IDLE); result = accumulator register.
- Arithmetic: unsigned; no overflow possible with default widths (15·225 = 3375 < 4096).
- Reset value of every output: in_ready=0, out_valid=0, busy=0, result=0. Reset asserted in any state → IDLE, count=0, accumulator=0. In-flight data is discarded.

## Timing
- start sampled at edge t → in_ready=1 and busy=1 from cycle t+1.
- Throughput: one beat per cycle while in_valid stays high.
- The last beat is accepted at edge t → out_valid=1 with the final result from cycle t+1. Accumulate-to-result latency is 1 cycle.
- in_ready drops in the cycle after the last beat; a surplus in_valid is not consumed.
- out_ready high at edge t while in DONE → IDLE at t+1. The next start can be sampled at edge t+1.
- Minimum job turnaround with len=N and continuous valid/ready: N+2 cycles start-to-start.
- len=0 job: out_valid=1 with result=0 one cycle after start.
- Reset deassertion: the first start can be sampled on the first rising edge after reset falls.

## Test plan
- start, len=3, beats (2,3),(4,5),(15,15), out_ready=1 → result=251, out_valid for 1 cycle, in_ready high for exactly 3 beat cycles.
- len=15, all beats A=B=15, in_valid toggled every other cycle → result=3375. Only valid cycles are counted. in_ready stays high throughout RUN.
- len=0 → out_valid=1, result=0 at start+1. in_ready never asserts.
- Hold the result with out_ready=0 for 5 cycles, apply start pulses and in_valid=1 → result stable, no beat consumed, start ignored. Assert out_ready → IDLE next cycle.
- len=4, abort after 2 beats coincident with a third valid beat → IDLE next cycle, busy=0, no out_valid. A new job len=1 with (3,3) then gives result=9, confirming the accumulator was cleared.
- Assert reset mid-RUN after 2 beats → all outputs 0 immediately, without waiting for an edge. After release, a len=2 job with (1,1),(1,1) gives result=2.
